// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  // Receiver/transmitter FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  // 100 MHz system clock at 9600 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 10417;

  // 8N1 framing
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/odbiornik_uart.sv
// UART receiver, 8N1, LSB first. Mid-bit sampling from the detected start edge;
// framing errors drop the byte and wait for the line to return high.
module odbiornik_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IdxLast  = 3'(DATA_BITS - 1);

  logic            rxd_s;
  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_sync_rxd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rxd_i),
    .q_o    (rxd_s)
  );

  // Next-state, counter and output-pulse logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at mid-start: glitch, not a frame
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          sh_d  = {rxd_s, sh_q[7:1]};
          if (idx_q == IdxLast) state_d = STOP;
          else                  idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_IDLE: begin
        // Hold off until the break clears so it is not decoded as 0x00 frames
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_odbiornik_uart.sv
// Directed bench for odbiornik_uart with 16 clocks per bit.
`timescale 1ns / 1ps
module tb_odbiornik_uart;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  odbiornik_uart #(
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rxd_i       (rxd),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Edge counter: value at a negedge is the index of the preceding posedge
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one frame aligned to negedges, 16 cycles per bit; line left at stop_bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (Cpb) @(negedge clk);
  endtask

  // Drive one frame with an arbitrary bit period in ns
  task automatic send_async(input logic [7:0] b, input real bit_ns);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = 1'b1;
    #(bit_ns);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", data_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_vec++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", frame_err_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single();
    int e, nv, nf, hit;
    logic [7:0] d;
    nv = 0; nf = 0; hit = -1; d = 8'h00;
    @(negedge clk);
    e = cyc + 1;
    fork
      send_frame(8'h41, 1'b1);
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (valid_o) begin nv++; hit = cyc + 1; d = data_o; end
        if (frame_err_o) nf++;
      end
    join
    n_vec++; if (nv != 1) begin n_err++; $display("FAIL single_pulses got %0d want 1", nv); end
    n_vec++; if (hit != e + 155) begin n_err++; $display("FAIL single_timing got E+%0d want E+155", hit - e); end
    n_vec++; if (d !== 8'h41) begin n_err++; $display("FAIL single_data got %h want 41", d); end
    n_vec++; if (nf != 0) begin n_err++; $display("FAIL single_ferr got %0d want 0", nf); end
  endtask

  task automatic test_back_to_back();
    int nv, h0, h1;
    logic [7:0] d0, d1;
    nv = 0; h0 = 0; h1 = 0; d0 = 8'hxx; d1 = 8'hxx;
    @(negedge clk);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      for (int k = 0; k < 360; k++) begin
        @(negedge clk);
        if (valid_o) begin
          if (nv == 0) begin h0 = cyc; d0 = data_o; end
          else begin h1 = cyc; d1 = data_o; end
          nv++;
        end
      end
    join
    n_vec++; if (nv != 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", nv); end
    n_vec++; if (h1 - h0 != 160) begin n_err++; $display("FAIL b2b_spacing got %0d want 160", h1 - h0); end
    n_vec++; if (d0 !== 8'h00) begin n_err++; $display("FAIL b2b_data0 got %h want 00", d0); end
    n_vec++; if (d1 !== 8'hFF) begin n_err++; $display("FAIL b2b_data1 got %h want ff", d1); end
    n_vec++; if (data_o !== 8'hFF) begin n_err++; $display("FAIL b2b_hold got %h want ff", data_o); end
  endtask

  task automatic test_glitch();
    int nv, nf, nb;
    nv = 0; nf = 0; nb = 0;
    @(negedge clk);
    fork
      begin
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
      end
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (valid_o) nv++;
        if (frame_err_o) nf++;
        if (busy_o) nb++;
      end
    join
    n_vec++; if (nv != 0) begin n_err++; $display("FAIL glitch_valid got %0d want 0", nv); end
    n_vec++; if (nf != 0) begin n_err++; $display("FAIL glitch_ferr got %0d want 0", nf); end
    n_vec++; if (nb != 8) begin n_err++; $display("FAIL glitch_busy got %0d cycles want 8", nb); end
    nv = 0;
    fork
      send_frame(8'h5A, 1'b1);
      for (int k = 0; k < 180; k++) begin
        @(negedge clk);
        if (valid_o) nv++;
      end
    join
    n_vec++; if (nv != 1) begin n_err++; $display("FAIL glitch_next_pulses got %0d want 1", nv); end
    n_vec++; if (data_o !== 8'h5A) begin n_err++; $display("FAIL glitch_next_data got %h want 5a", data_o); end
  endtask

  task automatic test_frame_error();
    int nv, nf;
    logic b_low, b_after;
    nv = 0; nf = 0; b_low = 1'b0; b_after = 1'b1;
    @(negedge clk);
    fork
      begin
        send_frame(8'h33, 1'b0);
        repeat (50) @(negedge clk);
        b_low = busy_o;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        b_after = busy_o;
      end
      for (int k = 0; k < 214; k++) begin
        @(negedge clk);
        if (valid_o) nv++;
        if (frame_err_o) nf++;
      end
    join
    n_vec++; if (nf != 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", nf); end
    n_vec++; if (nv != 0) begin n_err++; $display("FAIL ferr_valid got %0d want 0", nv); end
    n_vec++; if (data_o !== 8'h5A) begin n_err++; $display("FAIL ferr_data got %h want 5a", data_o); end
    n_vec++; if (b_low !== 1'b1) begin n_err++; $display("FAIL ferr_busy_low got %b want 1", b_low); end
    n_vec++; if (b_after !== 1'b0) begin n_err++; $display("FAIL ferr_busy_after got %b want 0", b_after); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int nv;
    b = 8'hA5;
    nv = 0;
    @(negedge clk);
    rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd = b[4];
    repeat (8) @(negedge clk);
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got %b want 1", busy_o); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (data_o !== 8'h00) begin n_err++; $display("FAIL rstmid_data got %h want 00", data_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    n_vec++; if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pulses got %b%b want 00", valid_o, frame_err_o);
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    fork
      send_frame(8'h7E, 1'b1);
      for (int k = 0; k < 180; k++) begin
        @(negedge clk);
        if (valid_o) nv++;
      end
    join
    n_vec++; if (nv != 1) begin n_err++; $display("FAIL rstmid_next_pulses got %0d want 1", nv); end
    n_vec++; if (data_o !== 8'h7E) begin n_err++; $display("FAIL rstmid_next_data got %h want 7e", data_o); end
  endtask

  task automatic test_random_skew();
    logic [7:0] q[200];
    int nf;
    nf = 0;
    for (int i = 0; i < 200; i++) q[i] = 8'($urandom);
    @(negedge clk);
    fork
      for (int i = 0; i < 200; i++) begin
        int s;
        real bit_ns;
        s = $urandom_range(0, 2);
        bit_ns = (s == 0) ? 156.8 : ((s == 1) ? 160.0 : 163.2);
        send_async(q[i], bit_ns);
        #(bit_ns * $urandom_range(0, 2));
      end
      for (int i = 0; i < 200; i++) begin
        bit got;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
          @(negedge clk);
          if (frame_err_o) nf++;
          if (valid_o) begin
            got = 1'b1;
            n_vec++;
            if (data_o !== q[i]) begin
              n_err++; $display("FAIL rand_byte%0d got %h want %h", i, data_o, q[i]);
            end
          end
        end
        if (!got) begin
          n_vec++; n_err++; $display("FAIL rand_timeout%0d got no valid want %h", i, q[i]);
        end
      end
    join
    n_vec++; if (nf != 0) begin n_err++; $display("FAIL rand_ferr got %0d want 0", nf); end
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_random_skew();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
